// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between an instruction-fetch
// port (I, read-only) and a data port (D, read/write).
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   i_req/i_addr                I-port request (held until i_ack) and address
//   i_ack/i_rdata               I-port one-cycle completion pulse and read data
//   d_req/d_we/d_addr/d_wdata   D-port request, direction, address, write data
//   d_ack/d_rdata               D-port one-cycle completion pulse and read data
//   mem_req/mem_we/mem_addr/
//   mem_wdata                   external bus request (held until mem_ack)
//   mem_ack/mem_rdata           external bus completion; read data same cycle
//   bus_err                     sticky watchdog-timeout flag, cleared by reset
//   busy                        high whenever the arbiter is not idle
//
// Simultaneous requests are resolved round-robin against the last grant. A
// watchdog (TIMEOUT cycles, 0 = off) abandons a stalled bus transaction, returns
// ERR_DATA for reads and sets bus_err. All outputs are registered.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StResp
    } state_e;

    localparam logic GrantI = 1'b0;
    localparam logic GrantD = 1'b1;

    localparam bit          WdogEn      = (TIMEOUT != 0);
    localparam logic [31:0] TimeoutLast = WdogEn ? 32'(TIMEOUT - 1) : 32'd0;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        busy_q, busy_d;

    logic grant_i, grant_d, timed_out;

    // I wins when alone or when D was served last; D takes whatever I does not.
    assign grant_i   = i_req && (!d_req || (last_grant_q == GrantD));
    assign grant_d   = d_req && !grant_i;
    assign timed_out = WdogEn && (cnt_q == TimeoutLast);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_ack_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        bus_err_d    = bus_err_q;

        unique case (state_q)
            StIdle: begin
                if (grant_i) begin
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr;
                    last_grant_d = GrantI;
                    cnt_d        = 32'd0;
                    state_d      = StBusyI;
                end else if (grant_d) begin
                    mem_req_d    = 1'b1;
                    mem_we_d     = d_we;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                    last_grant_d = GrantD;
                    cnt_d        = 32'd0;
                    state_d      = StBusyD;
                end
            end
            StBusyI: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    i_ack_d   = 1'b1;
                    i_rdata_d = mem_rdata;
                    state_d   = StResp;
                end else if (timed_out) begin
                    mem_req_d = 1'b0;
                    i_ack_d   = 1'b1;
                    i_rdata_d = ERR_DATA;
                    bus_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StBusyD: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    // Writes leave d_rdata at its previous value.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else if (timed_out) begin
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = ERR_DATA;
                    end
                    bus_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StResp: begin
                // Gap cycle so the requester's req drop is seen before re-arbitration.
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantD;
            cnt_q        <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            i_ack_q      <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_ack_q      <= 1'b0;
            d_rdata_q    <= 32'd0;
            bus_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ack_q      <= i_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_ack_q      <= d_ack_d;
            d_rdata_q    <= d_rdata_d;
            bus_err_q    <= bus_err_d;
            busy_q       <= busy_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8): single reads/writes, round-robin,
// watchdog timeout with sticky bus_err, reset mid-transaction, stray mem_ack.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_req, mem_we, bus_err, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .TIMEOUT (8),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .bus_err  (bus_err),
        .busy     (busy)
    );

    // One cycle: inputs set after this return are seen at the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int n;

    initial begin
        i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        do_reset();

        // Reset state
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk1("rst_i_ack", i_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);

        // Single I read, memory acks in the third busy cycle
        i_req = 1; i_addr = 32'h400;
        step();
        chk1("ird_mem_req_c1", mem_req, 1'b1);
        chk32("ird_mem_addr", mem_addr, 32'h400);
        chk1("ird_mem_we", mem_we, 1'b0);
        chk1("ird_busy", busy, 1'b1);
        i_addr = 32'hFFFF_0000;  // must be ignored after grant
        step();
        chk1("ird_mem_req_c2", mem_req, 1'b1);
        chk32("ird_addr_latched", mem_addr, 32'h400);
        step();
        chk1("ird_mem_req_c3", mem_req, 1'b1);
        mem_ack = 1; mem_rdata = 32'h8C220004;
        step();
        chk1("ird_i_ack", i_ack, 1'b1);
        chk32("ird_i_rdata", i_rdata, 32'h8C220004);
        chk1("ird_d_ack", d_ack, 1'b0);
        chk1("ird_mem_req_drop", mem_req, 1'b0);
        mem_ack = 0; i_req = 0;
        step();
        chk1("ird_i_ack_pulse", i_ack, 1'b0);
        chk1("ird_idle", busy, 1'b0);

        // D write with immediate mem_ack
        d_req = 1; d_we = 1; d_addr = 32'h1000; d_wdata = 32'hCAFEF00D;
        step();
        chk1("dwr_mem_req", mem_req, 1'b1);
        chk1("dwr_mem_we", mem_we, 1'b1);
        chk32("dwr_mem_addr", mem_addr, 32'h1000);
        chk32("dwr_mem_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        step();
        chk1("dwr_d_ack", d_ack, 1'b1);
        chk1("dwr_i_ack", i_ack, 1'b0);
        chk32("dwr_d_rdata_held", d_rdata, 32'h0);
        chk1("dwr_busy_resp", busy, 1'b1);
        mem_ack = 0; d_req = 0; d_we = 0;
        step();
        chk1("dwr_busy_fall", busy, 1'b0);
        chk1("dwr_d_ack_pulse", d_ack, 1'b0);

        // Stray mem_ack while idle with no requests
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        step();
        step();
        chk1("stray_i_ack", i_ack, 1'b0);
        chk1("stray_d_ack", d_ack, 1'b0);
        chk1("stray_busy", busy, 1'b0);
        chk1("stray_mem_req", mem_req, 1'b0);
        mem_ack = 0;

        // Round-robin after reset: both held, expect I, D, I
        do_reset();
        i_req = 1; i_addr = 32'h500;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h0000_0077;
        step();
        chk1("rr1_mem_req", mem_req, 1'b1);
        chk32("rr1_addr_i", mem_addr, 32'h500);
        mem_ack = 1; mem_rdata = 32'hA1;
        step();
        chk1("rr1_i_ack", i_ack, 1'b1);
        chk1("rr1_d_ack", d_ack, 1'b0);
        chk1("rr1_one_out", mem_req, 1'b0);
        mem_ack = 0;
        step();
        chk1("rr1_gap", mem_req, 1'b0);
        step();
        chk1("rr2_mem_req", mem_req, 1'b1);
        chk32("rr2_addr_d", mem_addr, 32'h2000);
        chk1("rr2_we", mem_we, 1'b1);
        mem_ack = 1;
        step();
        chk1("rr2_d_ack", d_ack, 1'b1);
        chk1("rr2_i_ack", i_ack, 1'b0);
        mem_ack = 0;
        step();
        step();
        chk1("rr3_mem_req", mem_req, 1'b1);
        chk32("rr3_addr_i", mem_addr, 32'h500);
        chk1("rr3_we", mem_we, 1'b0);
        mem_ack = 1; mem_rdata = 32'hA3;
        i_req = 0; d_req = 0; d_we = 0;
        step();
        chk1("rr3_i_ack", i_ack, 1'b1);
        chk32("rr3_i_rdata", i_rdata, 32'hA3);
        mem_ack = 0;
        step();

        // Watchdog: D read never acknowledged
        d_req = 1; d_we = 0; d_addr = 32'h3000;
        step();
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            if (n == 7) chk1("to_no_err_yet", bus_err, 1'b0);
            n++;
            step();
        end
        chk32("to_mem_req_cycles", 32'(n), 32'd8);
        chk1("to_d_ack", d_ack, 1'b1);
        chk32("to_d_rdata", d_rdata, 32'hDEADBEEF);
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_i_ack", i_ack, 1'b0);
        d_req = 0;
        step();
        step();

        // bus_err stays set through a good transaction
        i_req = 1; i_addr = 32'h600;
        step();
        mem_ack = 1; mem_rdata = 32'h600D;
        step();
        chk1("sticky_i_ack", i_ack, 1'b1);
        chk32("sticky_i_rdata", i_rdata, 32'h600D);
        chk1("sticky_bus_err", bus_err, 1'b1);
        mem_ack = 0; i_req = 0;
        step();
        step();
        chk1("sticky_bus_err2", bus_err, 1'b1);

        // Reset mid-transaction in BUSY_D
        d_req = 1; d_we = 0; d_addr = 32'h4000;
        step();
        chk1("mid_mem_req", mem_req, 1'b1);
        reset = 1;
        step();
        chk1("mid_mem_req_clr", mem_req, 1'b0);
        chk1("mid_busy_clr", busy, 1'b0);
        chk1("mid_bus_err_clr", bus_err, 1'b0);
        chk1("mid_d_ack", d_ack, 1'b0);
        chk32("mid_d_rdata", d_rdata, 32'h0);
        chk32("mid_mem_addr", mem_addr, 32'h0);
        reset = 0;
        i_req = 1; i_addr = 32'h700;
        step();
        chk1("post_mem_req", mem_req, 1'b1);
        chk32("post_grant_i", mem_addr, 32'h700);
        chk1("post_d_ack", d_ack, 1'b0);
        mem_ack = 1; mem_rdata = 32'h77;
        step();
        chk1("post_i_ack", i_ack, 1'b1);
        chk1("post_d_ack2", d_ack, 1'b0);
        mem_ack = 0; i_req = 0; d_req = 0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
